// File: rtl/regfile_issue.sv
// Multicycle issue/writeback stage around the ALU: latches one instruction, reads rs1/rs2
// from a 32x32 register file onto busA/busB, captures busC and writes it back to rd.
module regfile_issue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [XLEN-1:0] busA,
    output logic [XLEN-1:0] busB,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    input  logic [XLEN-1:0] busC,
    output logic            retire,
    output logic [31:0]     retire_cnt,
    input  logic            dbg_we,
    input  logic [4:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic [XLEN-1:0] dbg_rdata
);
    localparam int unsigned AW = 5;
    localparam int unsigned IW = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_ir;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_res;
    logic [31:0]       r_retire_cnt;
    logic [XLEN-1:0]   r_regs [NREGS];

    logic [AW-1:0]     w_rd;
    logic [AW-1:0]     w_rs1;
    logic [AW-1:0]     w_rs2;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic              w_ready;
    logic              w_retire;

    assign w_rd  = r_ir[11:7];
    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];

    // x0 reads as zero on every path
    assign w_rs1_val = (w_rs1 == AW'(0)) ? '0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == AW'(0)) ? '0 : r_regs[w_rs2];
    assign dbg_rdata = (dbg_addr == AW'(0)) ? '0 : r_regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (instr_valid) w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready  = 1'b0;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE:  w_ready  = 1'b1;
            S_WB:    w_retire = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_retire_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (instr_valid) r_ir <= instr;
                S_READ: begin
                    r_a <= w_rs1_val;
                    r_b <= w_rs2_val;
                end
                S_EXEC:  r_res <= busC;
                S_WB:    r_retire_cnt <= r_retire_cnt + 32'd1;
                default: ;
            endcase
        end
    end

    // Writeback and debug writes are state-exclusive, so one write port suffices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
        end else if (r_state == S_WB) begin
            if (w_rd != AW'(0)) r_regs[w_rd] <= r_res;
        end else if (r_state == S_IDLE && dbg_we && dbg_addr != AW'(0)) begin
            r_regs[dbg_addr] <= dbg_wdata;
        end
    end

    assign instr_ready = w_ready;
    assign retire      = w_retire;
    assign retire_cnt  = r_retire_cnt;
    assign busA        = r_a;
    assign busB        = r_b;
    assign op          = r_ir[6:0];
    assign funct3      = r_ir[14:12];
    assign funct7      = r_ir[31:25];

endmodule

// File: tb/tb_regfile_issue.sv
// Randomized self-checking bench for regfile_issue with a small ALU stand-in on busC
// and an array-based architectural register model.
module tb_regfile_issue;
    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] busA, busB, busC;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        retire;
    logic [31:0] retire_cnt;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;

    int checks;
    int failures;
    logic [31:0] m_reg [32];
    logic [31:0] m_cnt;
    logic [6:0]  op_tab [7];

    regfile_issue #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .busA(busA), .busB(busB), .op(op),
        .funct3(funct3), .funct7(funct7), .busC(busC), .retire(retire),
        .retire_cnt(retire_cnt), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcode meanings of the stand-in ALU; anything else yields 0
    function automatic logic [31:0] alu_f(input logic [6:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            7'b0001011: return a + b;
            7'b0001111: return a - b;
            7'b0010111: return ~a;
            7'b0010011: return a + 32'd1;
            7'b0100011: return a;
            7'b0000111: return a ^ b;
            default:    return 32'd0;
        endcase
    endfunction

    always_comb busC = alu_f(op, busA, busB);

    function automatic logic [31:0] enc(input logic [6:0] o, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'b000, rd, o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_dbg(input logic [4:0] a, input string tag);
        dbg_addr = a;
        #1;
        chk(tag, dbg_rdata, (a == 5'd0) ? 32'd0 : m_reg[a]);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (instr_ready !== 1'b1) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic dwrite(input logic [4:0] a, input logic [31:0] d);
        wait_ready();
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        tick();
        dbg_we = 1'b0;
        if (a != 5'd0) m_reg[a] = d;
    endtask

    // One full instruction: optional same-edge debug write, optional dropped debug write in READ
    task automatic issue(input logic [31:0] ins, input bit dw, input logic [4:0] da,
                         input logic [31:0] dd, input bit drop);
        logic [31:0] a, b;
        logic [4:0]  rd;
        wait_ready();
        chk("idle_ready", {31'd0, instr_ready}, 32'd1);
        instr = ins; instr_valid = 1'b1;
        dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        tick();
        instr_valid = 1'b0; dbg_we = 1'b0;
        if (dw && da != 5'd0) m_reg[da] = dd;
        a  = (ins[19:15] == 5'd0) ? 32'd0 : m_reg[ins[19:15]];
        b  = (ins[24:20] == 5'd0) ? 32'd0 : m_reg[ins[24:20]];
        rd = ins[11:7];
        chk("read_ready", {31'd0, instr_ready}, 32'd0);
        chk("op", {25'd0, op}, {25'd0, ins[6:0]});
        chk("funct3", {29'd0, funct3}, {29'd0, ins[14:12]});
        chk("funct7", {25'd0, funct7}, {25'd0, ins[31:25]});
        if (drop) begin
            dbg_we = 1'b1; dbg_addr = 5'd30; dbg_wdata = 32'hDEADBEEF;
        end
        tick();
        dbg_we = 1'b0;
        chk("exec_busA", busA, a);
        chk("exec_busB", busB, b);
        chk("exec_retire", {31'd0, retire}, 32'd0);
        tick();
        chk("wb_retire", {31'd0, retire}, 32'd1);
        tick();
        if (rd != 5'd0) m_reg[rd] = alu_f(ins[6:0], a, b);
        m_cnt = m_cnt + 32'd1;
        chk("post_retire", {31'd0, retire}, 32'd0);
        chk("post_ready", {31'd0, instr_ready}, 32'd1);
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("idle_busA", busA, a);
        rd_dbg(rd, "wb_rd");
        if (drop) rd_dbg(5'd30, "dropped_dbg_we");
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_cnt = 32'd0;
    endtask

    initial begin
        checks = 0; failures = 0;
        op_tab[0] = 7'b0001011; op_tab[1] = 7'b0001111; op_tab[2] = 7'b0010111;
        op_tab[3] = 7'b0010011; op_tab[4] = 7'b0100011; op_tab[5] = 7'b0000111;
        op_tab[6] = 7'b1110011;
        model_reset();
        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0;
        dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
        #12;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_busA", busA, 32'd0);
        chk("rst_busB", busB, 32'd0);
        chk("rst_op", {25'd0, op}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of EXEC aborts the instruction
        dwrite(5'd1, 32'd5);
        dwrite(5'd2, 32'd3);
        instr = enc(7'b0001011, 5'd3, 5'd1, 5'd2); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("pre_abort_busA", busA, 32'd5);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk("abort_busA", busA, 32'd0);
        chk("abort_busB", busB, 32'd0);
        chk("abort_cnt", retire_cnt, 32'd0);
        rd_dbg(5'd3, "abort_rd");
        rst_n = 1'b1;
        tick();
        repeat (4) tick();
        rd_dbg(5'd3, "abort_rd_later");

        // Directed cases
        dwrite(5'd1, 32'd5);
        dwrite(5'd2, 32'd3);
        issue(enc(7'b0001011, 5'd3, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b0);
        dwrite(5'd1, 32'd3);
        dwrite(5'd2, 32'd5);
        issue(enc(7'b0001111, 5'd4, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b0);
        issue(enc(7'b0010111, 5'd5, 5'd0, 5'd2), 1'b0, 5'd0, 32'd0, 1'b0);
        chk("x4_value", m_reg[4], 32'hFFFFFFFE);
        issue(enc(7'b0000111, 5'd0, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b0);
        dwrite(5'd0, 32'h12345678);
        rd_dbg(5'd0, "x0_dbg_write");

        // Back-to-back with instr_valid held high and a dependency
        dwrite(5'd1, 32'd5);
        dwrite(5'd20, 32'h0000AAAA);
        wait_ready();
        instr = enc(7'b0010011, 5'd6, 5'd1, 5'd0); instr_valid = 1'b1;
        tick();
        instr = enc(7'b0010011, 5'd7, 5'd6, 5'd0);
        for (int k = 0; k < 3; k++) begin
            chk("b2b_ready_low", {31'd0, instr_ready}, 32'd0);
            tick();
        end
        chk("b2b_ready_high", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        dbg_we = 1'b1; dbg_addr = 5'd20; dbg_wdata = 32'h00000055;
        tick();
        dbg_we = 1'b0;
        tick(); tick();
        chk("b2b_ready_again", {31'd0, instr_ready}, 32'd1);
        m_reg[6] = m_reg[1] + 32'd1;
        m_reg[7] = m_reg[6] + 32'd1;
        m_cnt = m_cnt + 32'd2;
        chk("b2b_cnt", retire_cnt, m_cnt);
        rd_dbg(5'd6, "b2b_x6");
        rd_dbg(5'd7, "b2b_x7");
        rd_dbg(5'd20, "b2b_dropped");

        // Debug write lands on the same edge as the accept
        issue(enc(7'b0100011, 5'd9, 5'd8, 5'd0), 1'b1, 5'd8, 32'h00000010, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            logic [31:0] ins;
            if ($urandom_range(0, 3) == 0) dwrite(5'($urandom_range(0, 31)), $urandom);
            ins = enc(op_tab[$urandom_range(0, 6)], 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            ins[14:12] = 3'($urandom_range(0, 7));
            ins[31:25] = 7'($urandom_range(0, 127));
            issue(ins, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 3) == 0));
            rd_dbg(5'($urandom_range(0, 31)), "rand_peek");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_issue.md
Name: regfile_issue

Overview:
- Multicycle issue/writeback stage sitting directly around the ALU.
- Accepts one 32-bit instruction through a valid/ready handshake and decodes the operation and register fields.
- Reads two source registers from an internal 32x32 register file and drives them onto busA/busB together with op/funct3/funct7.
- Captures the ALU result from busC and writes it back to rd. x0 is hardwired to zero.
- Includes a debug read/write port for preload and inspection.

Parameters:
XLEN, 32, datapath width (busA/busB/busC, register width)
NREGS, 32, number of architectural registers; address width is 5, fixed

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  upstream has an instruction on instr
instr  in  32  instruction word
instr_ready  out  1  stage can accept an instruction; equals (state==IDLE)
busA  out  XLEN  operand A to ALU (rs1 value)
busB  out  XLEN  operand B to ALU (rs2 value)
op  out  7  instr[6:0] of latched instruction
funct3  out  3  instr[14:12] of latched instruction
funct7  out  7  instr[31:25] of latched instruction
busC  in  XLEN  ALU result (combinational from busA/busB/op)
retire  out  1  one-cycle pulse in WB state
retire_cnt  out  32  count of retired instructions, wraps at 2^32
dbg_we  in  1  debug write request, honoured only in IDLE
dbg_addr  in  5  debug register address
dbg_wdata  in  XLEN  debug write data
dbg_rdata  out  XLEN  combinational read of reg[dbg_addr]; 0 for address 0

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; IR=0; operand latches A/B=0; result register=0; all registers=0; retire=0; retire_cnt=0.
  - Consequently busA=busB=0, op=funct3=funct7=0, and instr_ready=1 (asserted as soon as reset is applied).
  - Reset mid-instruction aborts it; no write to the register file occurs.
- Decode fields from IR: rd=IR[11:7], rs1=IR[19:15], rs2=IR[24:20]. op/funct3/funct7 are driven from IR in all states.
- FSM (4 states, one transition per clock):
  - IDLE: instr_ready=1. On instr_valid=1, IR<=instr and go to READ. Otherwise stay in IDLE.
  - READ: A<=reg[rs1], B<=reg[rs2] (reg[0] reads 0). Go to EXEC.
  - EXEC: busA=A, busB=B stable for the whole cycle. Result<=busC at the end of the cycle. Go to WB.
  - WB: if rd!=0 then reg[rd]<=result. retire=1; retire_cnt<=retire_cnt+1. Go to IDLE.
- busA/busB always reflect the A/B latches; they hold their last values while in IDLE.
- Latency and throughput:
  - Handshake accepted in cycle T.
  - Write to rd is visible via dbg_rdata from cycle T+4.
  - instr_ready re-asserts in cycle T+4, giving a throughput of 1 instruction per 4 cycles.
- No hazards are possible: each instruction completes writeback before the next is accepted. rs1==rd and rs2==rd read the old value.
- Write to x0 is discarded; x0 always reads 0 on every path.
- Debug port:
  - dbg_we is honoured only in IDLE. It is ignored (dropped) in any other state.
  - If dbg_we and instr_valid are both asserted in IDLE: both take effect. The debug write lands at the same edge as the IR load, so the following READ sees the debug-written value.
  - dbg_we to address 0 is ignored.
  - dbg_rdata read of the register being written in the same cycle returns the old value (write-first is not required).
- The op code is passed through unmodified. Unknown opcodes are executed and whatever busC returns (0 for unsupported ops) is written to rd.
- retire_cnt wraps from 0xFFFFFFFF to 0 without flag.

Test Plan:
- Reset then idle: assert rst_n=0 mid-EXEC -> state IDLE immediately, instr_ready=1, busA=busB=0, retire_cnt=0, target rd unchanged (reads 0).
- Preload x1=0x00000005 and x2=0x00000003 via dbg; issue op=0001011, rs1=1, rs2=2, rd=3 -> busA=5, busB=3 during EXEC; retire pulse 3 cycles after accept; dbg_rdata(3)=0x00000008 at T+4; retire_cnt=1.
- Issue op=0001111 with x1=3, x2=5, rd=4 -> x4=0xFFFFFFFE. Issue op=0010111 with rs1=0, rd=5 -> x5=0xFFFFFFFF.
- Write to x0: op=0000111, rd=0 -> retire pulses and retire_cnt increments, but dbg_rdata(0)=0.
- Back-to-back with instr_valid held high and dependency (rd=6 = x1+1, then rd=7 = x6+1, x1=5) -> instr_ready high only every 4th cycle; x6=6, x7=7; dbg_we asserted in READ is dropped (target register unchanged).
- Simultaneous dbg_we (addr 8, data 0x10) and accept of op=0100011, rs1=8, rd=9 -> x9=0x00000010.
